// File: rtl/cache_pkg.sv
// Shared width constants for the cache and its register-bus path.
package cache_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/axi_4_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one command into an AW/W/B or
// AR/R sequence and returns the response code and read data on a response stream.
module axi_4_lite_master_ctrl #(
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                  aclk_i,
  input  logic                  rst_i,
  // command stream
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [DATA_BYTES-1:0] cmd_wstrb_i,
  // response stream
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  // AW channel
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic [2:0]            awprot_o,
  // W channel
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_BYTES-1:0] wstrb_o,
  // B channel
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i,
  // AR channel
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [2:0]            arprot_o,
  // R channel
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]            state_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_BYTES-1:0] wstrb_reg;
  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic                  arvalid_reg;
  logic                  bready_reg;
  logic                  rready_reg;
  logic                  aw_done_reg;
  logic                  w_done_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic [1:0]            rsp_resp_reg;

  logic aw_fire;
  logic w_fire;
  logic aw_done_next;
  logic w_done_next;
  logic resp_fire;

  assign aw_fire      = awvalid_reg & awready_i;
  assign w_fire       = wvalid_reg & wready_i;
  // A handshake on this edge counts as done, so same-edge AW+W completes both.
  assign aw_done_next = aw_done_reg | aw_fire;
  assign w_done_next  = w_done_reg | w_fire;
  assign resp_fire    = (bready_reg & bvalid_i) | (rready_reg & rvalid_i);

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      bready_reg    <= 1'b0;
      rready_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid_i) begin
            we_reg    <= cmd_we_i;
            addr_reg  <= cmd_addr_i;
            wdata_reg <= cmd_wdata_i;
            wstrb_reg <= cmd_wstrb_i;
            if (cmd_we_i) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              aw_done_reg <= 1'b0;
              w_done_reg  <= 1'b0;
              state_reg   <= WR_REQ;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_fire) awvalid_reg <= 1'b0;
          if (w_fire)  wvalid_reg  <= 1'b0;
          aw_done_reg <= aw_done_next;
          w_done_reg  <= w_done_next;
          if (aw_done_next && w_done_next) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP, RD_RESP: begin
          if (resp_fire) begin
            bready_reg    <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= we_reg ? '0 : rdata_i;
            rsp_resp_reg  <= we_reg ? bresp_i : rresp_i;
            state_reg     <= RSP;
          end
        end
        RD_REQ: begin
          if (arready_i) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_RESP;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The only combinational output: gated by reset so nothing is accepted mid-reset.
  assign cmd_ready_o = (state_reg == IDLE) && !rst_i;

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_resp_o  = rsp_resp_reg;

  assign awvalid_o = awvalid_reg;
  assign awaddr_o  = addr_reg;
  assign awprot_o  = 3'b000;
  assign wvalid_o  = wvalid_reg;
  assign wdata_o   = wdata_reg;
  assign wstrb_o   = wstrb_reg;
  assign bready_o  = bready_reg;
  assign arvalid_o = arvalid_reg;
  assign araddr_o  = addr_reg;
  assign arprot_o  = 3'b000;
  assign rready_o  = rready_reg;

endmodule

// File: tb/tb_axi_4_lite_master_ctrl.sv
// Bench for axi_4_lite_master_ctrl: behavioural AXI4-Lite slave with per-channel
// ready/response delays, a response scoreboard and edge-count checks.
module tb_axi_4_lite_master_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic [DB-1:0] cmd_wstrb_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic [1:0]    rsp_resp_o;
  logic          awvalid_o, awready_i;
  logic [AW-1:0] awaddr_o;
  logic [2:0]    awprot_o;
  logic          wvalid_o, wready_i;
  logic [DW-1:0] wdata_o;
  logic [DB-1:0] wstrb_o;
  logic          bvalid_i, bready_o;
  logic [1:0]    bresp_i;
  logic          arvalid_o, arready_i;
  logic [AW-1:0] araddr_o;
  logic [2:0]    arprot_o;
  logic          rvalid_i, rready_o;
  logic [DW-1:0] rdata_i;
  logic [1:0]    rresp_i;

  always #5 clk = ~clk;

  axi_4_lite_master_ctrl dut (
    .aclk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awprot_o(awprot_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arprot_o(arprot_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Scoreboard entries are {rdata, resp}.
  logic [33:0] exp_q[$];

  // Slave configuration, written only by the stimulus process.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'd0, r_resp_cfg = 2'd0;
  logic [31:0] r_data_cfg = '0;

  // Monitor: owns all edge counters; samples pre-update values on the active edge.
  int   cyc = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
  int   aw_hs_cyc = 0, w_hs_cyc = 0, awv_cycles = 0, wv_cycles = 0;
  int   ar_rise_cyc = 0, acc_cyc = 0, rsp_hs_cyc = 0;
  logic arv_prev = 1'b0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;

  initial forever begin
    logic [33:0] e;
    @(posedge clk);
    cyc++;
    if (!rst_i) begin
      if (awvalid_o) awv_cycles++;
      if (wvalid_o)  wv_cycles++;
      if (awvalid_o && awready_i) begin aw_hs++; aw_hs_cyc = cyc; last_awaddr = awaddr_o; end
      if (wvalid_o && wready_i) begin
        w_hs++; w_hs_cyc = cyc; last_wdata = wdata_o; last_wstrb = wstrb_o;
      end
      if (bvalid_i && bready_o) b_hs++;
      if (arvalid_o && !arv_prev) ar_rise_cyc = cyc;
      if (arvalid_o && arready_i) begin ar_hs++; last_araddr = araddr_o; end
      if (cmd_valid_i && cmd_ready_o) acc_cyc = cyc;
      if (rsp_valid_o && rsp_ready_i) begin
        rsp_hs_cyc = cyc;
        check_eq("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rsp_rdata", rsp_rdata_o, e[33:2]);
          check_eq("rsp_resp", rsp_resp_o, e[1:0]);
        end
      end
    end
    arv_prev = arvalid_o;
  end

  // Slave: drives on the falling edge; a ready it raised last falling edge means a handshake happened.
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic bready_seen = 1'b0, rready_seen = 1'b0;

  initial begin
    awready_i = 0; wready_i = 0; arready_i = 0;
    bvalid_i = 0; rvalid_i = 0; bresp_i = 0; rresp_i = 0; rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        awready_i = 0; wready_i = 0; arready_i = 0; bvalid_i = 0; rvalid_i = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; bready_seen = 0; rready_seen = 0;
      end else begin
        if (awready_i) aw_pend = 1;
        if (wready_i)  w_pend = 1;
        if (arready_i) ar_pend = 1;
        if (bvalid_i && bready_seen) bvalid_i = 0;
        if (rvalid_i && rready_seen) rvalid_i = 0;
        if (!bvalid_i && aw_pend && w_pend) begin
          if (b_cnt >= b_delay) begin
            bvalid_i = 1; bresp_i = b_resp_cfg; aw_pend = 0; w_pend = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (!rvalid_i && ar_pend) begin
          if (r_cnt >= r_delay) begin
            rvalid_i = 1; rdata_i = r_data_cfg; rresp_i = r_resp_cfg; ar_pend = 0; r_cnt = 0;
          end else r_cnt++;
        end
        awready_i = awvalid_o && (aw_cnt >= aw_delay);
        if (!awvalid_o) aw_cnt = 0; else if (!awready_i) aw_cnt++;
        wready_i = wvalid_o && (w_cnt >= w_delay);
        if (!wvalid_o) w_cnt = 0; else if (!wready_i) w_cnt++;
        arready_i = arvalid_o && (ar_cnt >= ar_delay);
        if (!arvalid_o) ar_cnt = 0; else if (!arready_i) ar_cnt++;
        bready_seen = bready_o;
        rready_seen = rready_o;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [33:0] exp, input bit push);
    bit accepted = 0;
    cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_wstrb_i = wstrb;
    cmd_valid_i = 1;
    if (push) exp_q.push_back(exp);
    for (int t = 0; t < 200; t++) begin
      if (cmd_ready_o) begin accepted = 1; break; end
      @(negedge clk);
    end
    check_eq("cmd_accepted", accepted, 1);
    @(negedge clk);
    cmd_valid_i = 0;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, b0, ar0, awv0, wv0, wr_hs;
    rst_i = 1; cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = '0;
    cmd_wdata_i = '0; cmd_wstrb_i = '0; rsp_ready_i = 1;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready_o, 0);
    check_eq("rst_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 0);
    check_eq("rst_rsp", {rsp_rdata_o, rsp_resp_o}, 0);
    check_eq("rst_payload", {awaddr_o, wdata_o, wstrb_o, awprot_o, arprot_o}, 0);
    repeat (3) @(negedge clk);
    rst_i = 0;
    @(negedge clk);
    check_eq("post_rst_cmd_ready", cmd_ready_o, 1);

    // Write with immediate readies
    a0 = aw_hs; w0 = w_hs; b0 = b_hs;
    do_cmd(1, 32'h0, 32'h5, 4'hF, {32'h0, 2'd0}, 1);
    wait_drain("wr0_drain");
    check_eq("wr0_aw_hs", aw_hs - a0, 1);
    check_eq("wr0_w_hs", w_hs - w0, 1);
    check_eq("wr0_b_hs", b_hs - b0, 1);
    check_eq("wr0_aw_w_same_edge", aw_hs_cyc, w_hs_cyc);
    check_eq("wr0_payload", {last_awaddr, last_wdata, last_wstrb}, {32'h0, 32'h5, 4'hF});
    check_eq("wr0_latency", rsp_hs_cyc - acc_cyc, 3);

    // Skewed AW/W readies
    aw_delay = 3; awv0 = awv_cycles; wv0 = wv_cycles; b0 = b_hs;
    @(negedge clk);
    do_cmd(1, 32'h10, 32'hDEADBEEF, 4'h3, {32'h0, 2'd0}, 1);
    wait_drain("skew_drain");
    check_eq("skew_awvalid_cycles", awv_cycles - awv0, 4);
    check_eq("skew_wvalid_cycles", wv_cycles - wv0, 1);
    check_eq("skew_b_hs", b_hs - b0, 1);
    check_eq("skew_payload", {last_awaddr, last_wdata, last_wstrb}, {32'h10, 32'hDEADBEEF, 4'h3});
    aw_delay = 0;

    // Read
    r_data_cfg = 32'hA5A5A5A5; r_resp_cfg = 2'd0; ar0 = ar_hs;
    @(negedge clk);
    do_cmd(0, 32'h5, 32'h0, 4'h0, {32'hA5A5A5A5, 2'd0}, 1);
    wait_drain("rd_drain");
    check_eq("rd_ar_hs", ar_hs - ar0, 1);
    check_eq("rd_araddr", last_araddr, 32'h5);
    check_eq("rd_latency", rsp_hs_cyc - acc_cyc, 3);

    // Response backpressure
    rsp_ready_i = 0; r_data_cfg = 32'h12345678; r_resp_cfg = 2'd1;
    @(negedge clk);
    do_cmd(0, 32'h20, 32'h0, 4'h0, {32'h12345678, 2'd1}, 1);
    for (int t = 0; t < 50 && !rsp_valid_o; t++) @(negedge clk);
    check_eq("bp_rsp_valid", rsp_valid_o, 1);
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_cmd_ready", cmd_ready_o, 0);
      check_eq("bp_rsp_hold", {rsp_valid_o, rsp_rdata_o, rsp_resp_o}, {1'b1, 32'h12345678, 2'd1});
      @(negedge clk);
    end
    rsp_ready_i = 1;
    wait_drain("bp_drain");

    // Write then read back-to-back: AR may only start after the write response is consumed
    rsp_ready_i = 0; r_data_cfg = 32'hCAFEF00D; r_resp_cfg = 2'd0;
    @(negedge clk);
    do_cmd(1, 32'h30, 32'h77, 4'hF, {32'h0, 2'd0}, 1);
    fork
      do_cmd(0, 32'h34, 32'h0, 4'h0, {32'hCAFEF00D, 2'd0}, 1);
      begin repeat (6) @(negedge clk); rsp_ready_i = 1; end
    join
    wr_hs = rsp_hs_cyc;
    wait_drain("b2b_drain");
    check_eq("b2b_ar_after_rsp", ar_rise_cyc, wr_hs + 2);
    check_eq("b2b_araddr", last_araddr, 32'h34);

    // Reset in the middle of a write (AW stalled)
    aw_delay = 10;
    @(negedge clk);
    do_cmd(1, 32'h40, 32'h1, 4'hF, {32'h0, 2'd0}, 0);
    @(negedge clk);
    check_eq("mid_awvalid_before_rst", awvalid_o, 1);
    rst_i = 1;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 0);
    check_eq("mid_rst_cmd_ready", cmd_ready_o, 0);
    rst_i = 0;
    #1;
    check_eq("mid_idle_after_rst", cmd_ready_o, 1);
    aw_delay = 0;
    @(negedge clk);

    // Error pass-through
    b_resp_cfg = 2'd2;
    do_cmd(1, 32'h50, 32'hFF, 4'hF, {32'h0, 2'd2}, 1);
    wait_drain("slverr_drain");
    b_resp_cfg = 2'd0;
    r_data_cfg = 32'h0BAD0BAD; r_resp_cfg = 2'd3;
    @(negedge clk);
    do_cmd(0, 32'h54, 32'h0, 4'h0, {32'h0BAD0BAD, 2'd3}, 1);
    wait_drain("decerr_drain");

    repeat (3) @(negedge clk);
    check_eq("final_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_4_lite_master_ctrl.md
# axi_4_lite_master_ctrl

Single-outstanding AXI4-Lite master controller that sequences register accesses into `axi_4_lite_slave`. It converts a simple command/response stream (one command per transaction, read or write) into correctly ordered AW/W/B or AR/R handshakes. It sits between the CPU-side request logic and the slave's AXI ports, and returns the response code and read data on a response stream. Widths come from `cache_pkg`.

## Interface
- `ADDR_WIDTH`, default `cache_pkg::ADDR_WIDTH`, address width.
- `DATA_WIDTH`, default `cache_pkg::DATA_WIDTH`, data width.
- `DATA_BYTES`, default `DATA_WIDTH/8`, strobe width.
- `aclk_i` in 1: the single clock. All logic is clocked on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command accepted when high together with `cmd_valid_i`.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in ADDR_WIDTH: byte address.
- `cmd_wdata_i` in DATA_WIDTH: write data.
- `cmd_wstrb_i` in DATA_BYTES: write strobes.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out DATA_WIDTH: read data. Zero for writes.
- `rsp_resp_o` out 2: BRESP or RRESP of the completed transaction.
- `awvalid_o`/`awready_i`/`awaddr_o` out/in/out 1/1/ADDR_WIDTH: AW channel.
- `wvalid_o`/`wready_i` out/in 1/1: W channel handshake.
- `wdata_o`/`wstrb_o` out DATA_WIDTH/DATA_BYTES: W payload.
- `bvalid_i`/`bready_o`/`bresp_i` in/out/in 1/1/2: B channel.
- `arvalid_o`/`arready_i`/`araddr_o` out/in/out 1/1/ADDR_WIDTH: AR channel.
- `rvalid_i`/`rready_o` in/out 1/1: R channel handshake.
- `rdata_i`/`rresp_i` in DATA_WIDTH/2: R payload.

## Operation
- **FSM states:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- **IDLE:**
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`, register addr, wdata, wstrb and we.
  - Go to WR_REQ if we=1, otherwise RD_REQ.
- **WR_REQ:**
  - `awvalid_o` and `wvalid_o` rise together.
  - Each channel drops independently on its own handshake. Per-channel "done" flags record completion.
  - Leave for WR_RESP when both channels are done. A same-cycle handshake on both channels counts as both done.
- **WR_RESP:**
  - `bready_o`=1.
  - On `bvalid_i`, capture `bresp_i` and clear `rsp_rdata_o`. Go to RSP.
- **RD_REQ:** `arvalid_o`=1 until `arready_i`, then go to RD_RESP.
- **RD_RESP:**
  - `rready_o`=1.
  - On `rvalid_i`, capture `rdata_i`/`rresp_i`. Go to RSP.
- **RSP:**
  - `rsp_valid_o`=1, with the payload held stable.
  - On `rsp_ready_i`, go to IDLE.
- **Channel payloads:** all AXI address/data/strobe outputs are driven from the command registers and are stable while the corresponding valid is high.
- **Protection:** the protection fields are tied to 0 at the top level.
- **Outstanding transactions:** at most one transaction is outstanding. A new command is never accepted before the previous response is consumed.

## Timing
- **Registered outputs:** all valid/ready outputs are registered, except `cmd_ready_o`, which is decoded from the IDLE state.
- **Reset:**
  - While `rst_i`=1: `cmd_ready_o`=0.
  - On the edge with `rst_i`=1: all of awvalid, wvalid, arvalid, bready, rready and `rsp_valid_o` go to 0; `rsp_rdata_o` and `rsp_resp_o` go to 0; state goes to IDLE.
  - First cycle after `rst_i` falls: `cmd_ready_o`=1.
- **Command to AXI valid:** command accepted at edge N ⇒ AW/W or AR valid high from edge N to N+1.
- **Minimum write:**
  - With both readies high at edge N+1 and `bvalid_i` at edge N+2, `rsp_valid_o` is high after edge N+2.
  - Next command can be accepted the cycle after the response handshake.
- **Minimum read:** same timing as the minimum write, using AR/R in place of AW+W/B.
- **Valid/ready ordering:** no valid is ever withdrawn before its handshake. No valid depends combinationally on a ready.
- **Early responses:** `bvalid_i`/`rvalid_i` arriving before the controller reaches the matching RESP state are held by the slave and taken when `bready_o`/`rready_o` rises.
- **Reset mid-transaction:** the transaction is abandoned and all valids drop at the reset edge. The slave is reset by the same `rst_i` domain.
- **Response errors:** the SLVERR/DECERR codes are passed through unchanged. There is no retry.

## Test plan
- **Reset values:** hold `rst_i` 5 cycles ⇒ every output is 0 during reset, and `cmd_ready_o`=1 one cycle after release.
- **Write with immediate readies:** write addr 0x0, data 0x5, wstrb 0xF, slave readies high ⇒ AW and W handshake on the same edge, one B handshake, `rsp_resp_o`=0, `rsp_rdata_o`=0.
- **Skewed AW/W readies:** write with `awready_i` delayed 3 cycles and `wready_i` immediate ⇒ `wvalid_o` drops after 1 cycle, `awvalid_o` is held 4 cycles, and exactly one B handshake occurs.
- **Read:** read addr 0x5, slave returns rdata 0xA5A5A5A5, rresp 0 ⇒ `rsp_rdata_o`=0xA5A5A5A5.
- **Response backpressure:** hold `rsp_ready_i`=0 for 4 cycles ⇒ `cmd_ready_o`=0 and the response is stable throughout. Write-then-read back-to-back ⇒ the read's AR starts only after the write response is consumed.
- **Mid-transaction reset and error pass-through:** assert `rst_i` while in WR_REQ ⇒ all valids are 0 after the edge and the FSM is back in IDLE. A slave returning bresp=2 ⇒ `rsp_resp_o`=2.
